// File: rtl/direction_ctrl.sv
// direction_ctrl: button conditioning, move arbitration and game tick.
// Commits the pending move on the falling edge of update_clk.
module direction_ctrl #(
    parameter int DEBOUNCE_CYCLES  = 250000,
    parameter int TICK_HALF_PERIOD = 1250000
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       btn_left,
    input  logic       btn_up,
    input  logic       btn_right,
    input  logic       btn_down,
    input  logic       game_over,
    output logic [0:1] direction,
    output logic       update_clk,
    output logic       dir_changed
);

    localparam logic [1:0] LEFT_DIR  = 2'd0;
    localparam logic [1:0] TOP_DIR   = 2'd1;
    localparam logic [1:0] RIGHT_DIR = 2'd2;
    localparam logic [1:0] DOWN_DIR  = 2'd3;

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = (TICK_HALF_PERIOD > 1) ? $clog2(TICK_HALF_PERIOD) : 1;
    localparam logic [DW-1:0] DB_TC = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TK_TC = TW'(TICK_HALF_PERIOD - 1);

    // bit 0 left, 1 up, 2 right, 3 down
    logic [3:0]    w_raw;
    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [3:0]    r_db;
    logic [3:0]    r_db_d;
    logic [DW-1:0] r_db_cnt [4];
    logic [3:0]    w_press;
    logic          w_press_any;
    logic [1:0]    w_press_dir;
    logic          r_req_valid;
    logic [1:0]    r_req;
    logic [TW-1:0] r_tick_cnt;
    logic          r_update_clk;
    logic          w_tc;
    logic          w_fall;
    logic          w_commit;
    logic [1:0]    r_dir;
    logic          r_dir_changed;

    assign w_raw = {btn_down, btn_right, btn_up, btn_left};

    // two-flop synchronizer per button
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // per-button debounce: level must hold DEBOUNCE_CYCLES before it is accepted
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_db   <= '0;
            r_db_d <= '0;
            for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
        end else begin
            r_db_d <= r_db;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_TC) begin
                    r_db[i]     <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
                end
            end
        end
    end

    assign w_press     = r_db & ~r_db_d;
    assign w_press_any = |w_press;

    // fixed-priority pick among simultaneous presses
    always_comb begin
        w_press_dir = RIGHT_DIR;
        priority case (1'b1)
            w_press[0]: w_press_dir = LEFT_DIR;
            w_press[1]: w_press_dir = TOP_DIR;
            w_press[2]: w_press_dir = RIGHT_DIR;
            w_press[3]: w_press_dir = DOWN_DIR;
            default:    w_press_dir = RIGHT_DIR;
        endcase
    end

    // game tick divider, free running
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt   <= '0;
            r_update_clk <= 1'b0;
        end else if (w_tc) begin
            r_tick_cnt   <= '0;
            r_update_clk <= ~r_update_clk;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    assign w_tc   = (r_tick_cnt == TK_TC);
    assign w_fall = w_tc & r_update_clk;

    // reject no-op and reversal moves; opposite encodings differ in bit 1
    assign w_commit = w_fall & r_req_valid & ~game_over &
                      (r_req != r_dir) &
                      (r_req != (r_dir ^ 2'b10));

    // pending request: a fresh press beats the commit-edge clear
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_req_valid <= 1'b0;
            r_req       <= RIGHT_DIR;
        end else if (game_over) begin
            r_req_valid <= 1'b0;
        end else if (w_press_any) begin
            r_req_valid <= 1'b1;
            r_req       <= w_press_dir;
        end else if (w_fall) begin
            r_req_valid <= 1'b0;
        end
    end

    // committed direction and change pulse
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_dir         <= RIGHT_DIR;
            r_dir_changed <= 1'b0;
        end else begin
            r_dir_changed <= w_commit;
            if (w_commit) r_dir <= r_req;
        end
    end

    assign direction   = r_dir;
    assign update_clk  = r_update_clk;
    assign dir_changed = r_dir_changed;

endmodule

// File: tb/tb_direction_ctrl.sv
// tb_direction_ctrl: table-driven tick-by-tick checks of direction_ctrl.
// Expected commits are queued when stimulus is applied, popped at each fall.
module tb_direction_ctrl;

    localparam int LEFT  = 0;
    localparam int TOP   = 1;
    localparam int RIGHT = 2;
    localparam int DOWN  = 3;

    typedef struct {
        logic [3:0] btn;
        int         hold;
        int         go_len;
        int         dir;
        int         chg;
    } vec_t;

    typedef struct {
        int dir;
        int chg;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] btn;
    logic       go;
    logic [0:1] dir;
    logic       upd;
    logic       chg;

    int   checks;
    int   failures;
    int   cyc;
    int   n_falls;
    int   prev_upd;
    int   prev_dir;
    exp_t exp_q[$];
    vec_t vecs[12];

    direction_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .TICK_HALF_PERIOD(8)
    ) dut (
        .vga_clk(clk),
        .reset(rst),
        .btn_left(btn[0]),
        .btn_up(btn[1]),
        .btn_right(btn[2]),
        .btn_down(btn[3]),
        .game_over(go),
        .direction(dir),
        .update_clk(upd),
        .dir_changed(chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d",
                     name, cyc, act, exp);
        end
    endtask

    task automatic push(input int d, input int c);
        exp_t e;
        e.dir = d;
        e.chg = c;
        exp_q.push_back(e);
    endtask

    // monitor: tick edges on multiples of 8, commits only at falls
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (int'(upd) != prev_upd) begin
                chk("tick_edge_phase", cyc % 8, 0);
                if (prev_upd == 1) begin
                    n_falls++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_fall", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("fall_dir", int'(dir), e.dir);
                        chk("fall_chg", int'(chg), e.chg);
                    end
                end
            end else begin
                chk("quiet_chg", int'(chg), 0);
                chk("quiet_dir", int'(dir), prev_dir);
            end
        end
        prev_upd = int'(upd);
        prev_dir = int'(dir);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_fall();
        int start;
        int n;
        start = n_falls;
        n = 0;
        while (n_falls == start && n < 40) begin
            tick();
            n++;
        end
        if (n_falls == start) chk("fall_timeout", 0, 1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        n_falls  = 0;
        prev_upd = 0;
        prev_dir = RIGHT;
        rst = 1'b1;
        btn = 4'b0000;
        go  = 1'b0;

        vecs[0]  = '{4'b0100, 5, 0,  RIGHT, 1};
        vecs[1]  = '{4'b0001, 5, 0,  RIGHT, 0};
        vecs[2]  = '{4'b1000, 5, 0,  DOWN,  1};
        vecs[3]  = '{4'b0001, 3, 0,  DOWN,  0};
        vecs[4]  = '{4'b0100, 5, 0,  RIGHT, 1};
        vecs[5]  = '{4'b0010, 5, 0,  TOP,   1};
        vecs[6]  = '{4'b1001, 5, 0,  LEFT,  1};
        vecs[7]  = '{4'b1100, 5, 0,  LEFT,  0};
        vecs[8]  = '{4'b0110, 5, 0,  TOP,   1};
        vecs[9]  = '{4'b0001, 5, 10, TOP,   0};
        vecs[10] = '{4'b0100, 5, 16, TOP,   0};
        vecs[11] = '{4'b0000, 0, 0,  TOP,   0};

        repeat (3) tick();
        chk("rst_dir", int'(dir), RIGHT);
        chk("rst_upd", int'(upd), 0);
        chk("rst_chg", int'(chg), 0);

        // idle tick pattern after reset
        push(RIGHT, 0);
        push(RIGHT, 0);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            chk("idle_upd", int'(upd), (cyc / 8) % 2);
            chk("idle_dir", int'(dir), RIGHT);
        end
        chk("idle_queue", exp_q.size(), 0);

        // held up press from cycle 2: one commit, no repeat
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        btn = 4'b0010;
        push(TOP, 1);
        push(TOP, 0);
        wait_fall();
        wait_fall();
        btn = 4'b0000;

        for (int i = 0; i < 12; i++) begin
            btn = vecs[i].btn;
            go  = (vecs[i].go_len > 0);
            push(vecs[i].dir, vecs[i].chg);
            for (int c = 0; c < 14; c++) begin
                tick();
                if (c + 1 >= vecs[i].hold)   btn = 4'b0000;
                if (c + 1 >= vecs[i].go_len) go = 1'b0;
            end
            wait_fall();
            go = 1'b0;
        end

        // latest press wins: right then left within one tick
        push(LEFT, 1);
        btn = 4'b0100;
        repeat (5) tick();
        btn = 4'b0000;
        repeat (3) tick();
        btn = 4'b0001;
        repeat (5) tick();
        btn = 4'b0000;
        wait_fall();

        // press captured on the commit edge waits for the next tick
        push(LEFT, 0);
        push(TOP, 1);
        repeat (9) tick();
        btn = 4'b0010;
        repeat (5) tick();
        btn = 4'b0000;
        wait_fall();
        wait_fall();

        // async reset mid-debounce with update_clk high
        repeat (5) tick();
        btn = 4'b1000;
        repeat (5) tick();
        chk("pre_rst_upd", int'(upd), 1);
        chk("pre_rst_queue", exp_q.size(), 0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_dir", int'(dir), RIGHT);
        chk("async_rst_upd", int'(upd), 0);
        chk("async_rst_chg", int'(chg), 0);
        repeat (2) tick();
        rst = 1'b0;
        push(DOWN, 1);
        push(DOWN, 0);
        wait_fall();
        chk("post_rst_fall_cycle", cyc, 16);
        wait_fall();
        btn = 4'b0000;
        repeat (4) tick();
        chk("final_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
